// File: rtl/vlane_wb_align_if.sv
// ---------------------------------------------------------------------------
// vlane_wb_align_if
//
// Bundles the issue side and the register-file write side of the lane
// writeback aligner.
//
//   issue_valid_i    upstream -> aligner  operation issued this cycle
//   issue_ready_o    aligner  -> upstream aligner can accept an issue
//   issue_is_mul_i   upstream -> aligner  operation is a multiply / MAC
//   issue_mask_en_i  upstream -> aligner  element active (0 = no writeback)
//   issue_addr_i     upstream -> aligner  destination element address
//   alu_res_i        upstream -> aligner  ALU result, valid in the issue cycle
//   mul_res_i        upstream -> aligner  multiplier result, PIPE_ST-1 later
//   wb_valid_o       aligner  -> regfile  write request
//   wb_ready_i       regfile  -> aligner  write accepted
//   wb_addr_o        aligner  -> regfile  write address
//   wb_data_o        aligner  -> regfile  write data
//
// slave  : seen from the aligner
// master : seen from the environment driving the aligner
// ---------------------------------------------------------------------------
interface vlane_wb_align_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 5
);
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic                  issue_is_mul_i;
  logic                  issue_mask_en_i;
  logic [ADDR_W-1:0]     issue_addr_i;
  logic [DATA_WIDTH-1:0] alu_res_i;
  logic [DATA_WIDTH-1:0] mul_res_i;
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [ADDR_W-1:0]     wb_addr_o;
  logic [DATA_WIDTH-1:0] wb_data_o;

  modport slave (
    input  issue_valid_i, issue_is_mul_i, issue_mask_en_i, issue_addr_i,
    input  alu_res_i, mul_res_i, wb_ready_i,
    output issue_ready_o, wb_valid_o, wb_addr_o, wb_data_o
  );

  modport master (
    output issue_valid_i, issue_is_mul_i, issue_mask_en_i, issue_addr_i,
    output alu_res_i, mul_res_i, wb_ready_i,
    input  issue_ready_o, wb_valid_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/vlane_wb_align.sv
// ---------------------------------------------------------------------------
// vlane_wb_align
//
// Per-lane writeback aligner. Single-cycle ALU results and fixed-latency
// multiplier results are merged into a small result FIFO whose head drives
// the register-file write port. A credit check on issue guarantees that every
// multiplier result already in flight owns a FIFO slot, so the FIFO can never
// overflow and the tag pipe never stalls.
//
// Ports:
//   clk_i     clock
//   resetn_i  asynchronous active-low reset
//   flush_i   synchronous clear of the FIFO and the tag pipe
//   bus       vlane_wb_align_if.slave (issue side + write side)
//
// Optional build macro:
//   ALU_BYPASS_EN  an active ALU result skips the FIFO and appears on the
//                  write port in its issue cycle when the FIFO is empty, no
//                  multiplier result completes and wb_ready_i is high.
// ---------------------------------------------------------------------------
module vlane_wb_align #(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_ST    = 5,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 flush_i,
  vlane_wb_align_if.slave      bus
);

  localparam int TAG_ST = PIPE_ST - 1;          // tag pipe depth
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + $clog2(PIPE_ST) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } tag_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  tag_t [TAG_ST-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            mem_q [FIFO_DEPTH];

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic [SUM_W-1:0] inflight;
  logic [SUM_W-1:0] credit_need;
  logic             issue_ready;
  logic             accept;
  logic             alu_req;
  logic             mul_issue;
  logic             mul_done;
  logic             fifo_empty;
  logic             bypass;
  logic             mul_push;
  logic             alu_push;
  logic             pop;
  logic [PTR_W-1:0] alu_idx;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < TAG_ST; i++) begin
      inflight = inflight + SUM_W'(tag_q[i].valid);
    end
  end

  // Credit: reserve one slot for this issue plus one per result in flight.
  // Depends on registered state only, never on issue_valid_i.
  assign credit_need = SUM_W'(count_q) + inflight + SUM_W'(1);
  assign issue_ready = (credit_need <= SUM_W'(FIFO_DEPTH));

  assign accept     = bus.issue_valid_i && issue_ready && !flush_i;
  assign alu_req    = accept && bus.issue_mask_en_i && !bus.issue_is_mul_i;
  assign mul_issue  = accept && bus.issue_mask_en_i &&  bus.issue_is_mul_i;
  assign mul_done   = tag_q[TAG_ST-1].valid;
  assign fifo_empty = (count_q == '0);

`ifdef ALU_BYPASS_EN
  assign bypass = alu_req && fifo_empty && !mul_done && bus.wb_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign mul_push = mul_done && !flush_i;
  assign alu_push = alu_req && !bypass;   // alu_req already excludes flush
  assign pop      = !fifo_empty && bus.wb_ready_i;

  // On a collision the multiplier entry takes the lower slot and pops first.
  assign alu_idx  = wr_ptr_q + PTR_W'(mul_push);

  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      tag_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      tag_d[0].valid = mul_issue;
      tag_d[0].addr  = bus.issue_addr_i;
      for (int i = 1; i < TAG_ST; i++) begin
        tag_d[i] = tag_q[i-1];
      end
      // Pointers wrap naturally: FIFO_DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PTR_W'(mul_push) + PTR_W'(alu_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(mul_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // once count_q says it was written, and the outputs are zeroed while empty.
  always_ff @(posedge clk_i) begin
    if (mul_push) begin
      mem_q[wr_ptr_q] <= '{addr: tag_q[TAG_ST-1].addr, data: bus.mul_res_i};
    end
    if (alu_push) begin
      mem_q[alu_idx] <= '{addr: bus.issue_addr_i, data: bus.alu_res_i};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The head entry is held until popped, so address and data stay stable
  // under backpressure. While empty the port reads zero.
  always_comb begin
    bus.wb_addr_o = '0;
    bus.wb_data_o = '0;
    if (!fifo_empty) begin
      bus.wb_addr_o = mem_q[rd_ptr_q].addr;
      bus.wb_data_o = mem_q[rd_ptr_q].data;
    end else if (bypass) begin
      bus.wb_addr_o = bus.issue_addr_i;
      bus.wb_data_o = bus.alu_res_i;
    end
  end

  assign bus.wb_valid_o    = !fifo_empty || bypass;
  assign bus.issue_ready_o = issue_ready;

endmodule

// File: tb/tb_vlane_wb_align.sv
// ---------------------------------------------------------------------------
// tb_vlane_wb_align
//
// Self-checking bench for vlane_wb_align. A queue-based reference model holds
// the expected write sequence and the multiplier results still in flight;
// every cycle the write port and issue_ready_o are compared against it.
// ---------------------------------------------------------------------------
module tb_vlane_wb_align;

  localparam int DW    = 32;
  localparam int PST   = 5;
  localparam int AW    = 5;
  localparam int DEPTH = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mul_t;

  logic clk_i;
  logic resetn_i;
  logic flush_i;

  vlane_wb_align_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  vlane_wb_align #(
    .DATA_WIDTH (DW),
    .PIPE_ST    (PST),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .flush_i  (flush_i),
    .bus      (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  wr_t  exp_q[$];
  mul_t mul_q[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      $error("check %s", tag);
    end
  endtask

  task automatic idle_inputs();
    bus.issue_valid_i   = 1'b0;
    bus.issue_is_mul_i  = 1'b0;
    bus.issue_mask_en_i = 1'b0;
    bus.issue_addr_i    = '0;
    bus.alu_res_i       = '0;
    bus.mul_res_i       = '0;
    bus.wb_ready_i      = 1'b1;
    flush_i             = 1'b0;
  endtask

  // One clock cycle. Called just after a rising edge; drives inputs, checks
  // outputs on the falling edge, then advances the reference model across
  // the next rising edge.
  task automatic cycle(input bit v, input bit m, input bit en,
                       input logic [AW-1:0] a, input logic [DW-1:0] alu,
                       input logic [DW-1:0] md, input bit rdy, input bit fl);
    bit   mul_done;
    bit   acc;
    bit   bypass;
    bit   exp_ready;
    wr_t  w;
    mul_t t;
    bus.issue_valid_i   = v;
    bus.issue_is_mul_i  = m;
    bus.issue_mask_en_i = en;
    bus.issue_addr_i    = a;
    bus.alu_res_i       = alu;
    bus.wb_ready_i      = rdy;
    flush_i             = fl;
    mul_done = (mul_q.size() > 0) && (mul_q[0].due == cyc);
    bus.mul_res_i = mul_done ? mul_q[0].data : DW'($urandom);

    @(negedge clk_i);
    exp_ready = (exp_q.size() + mul_q.size() + 1) <= DEPTH;
    check("issue_ready", 64'(bus.issue_ready_o), 64'(exp_ready));
    acc    = v && exp_ready && !fl;
    bypass = 1'b0;
`ifdef ALU_BYPASS_EN
    bypass = acc && en && !m && (exp_q.size() == 0) && !mul_done && rdy;
`endif
    if (bypass) begin
      check("wb_valid", 64'(bus.wb_valid_o), 64'(1));
      check("wb_addr",  64'(bus.wb_addr_o),  64'(a));
      check("wb_data",  64'(bus.wb_data_o),  64'(alu));
    end else if (exp_q.size() > 0) begin
      check("wb_valid", 64'(bus.wb_valid_o), 64'(1));
      check("wb_addr",  64'(bus.wb_addr_o),  64'(exp_q[0].addr));
      check("wb_data",  64'(bus.wb_data_o),  64'(exp_q[0].data));
    end else begin
      check("wb_valid", 64'(bus.wb_valid_o), 64'(0));
    end

    @(posedge clk_i);
    if (fl) begin
      exp_q.delete();
      mul_q.delete();
    end else begin
      if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
      if (mul_done) begin
        w.addr = mul_q[0].addr;
        w.data = mul_q[0].data;
        exp_q.push_back(w);
        void'(mul_q.pop_front());
      end
      if (acc && en && !m && !bypass) begin
        w.addr = a;
        w.data = alu;
        exp_q.push_back(w);
      end
      if (acc && en && m) begin
        t.due  = cyc + PST - 1;
        t.addr = a;
        t.data = md;
        mul_q.push_back(t);
      end
      // A push into a full FIFO must never happen.
      check("no_overflow", 64'(exp_q.size() <= DEPTH), 64'(1));
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, '0, rdy, 0);
  endtask

  task automatic alu_op(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit rdy);
    cycle(1, 0, 1, a, d, '0, rdy, 0);
  endtask

  task automatic mul_op(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit rdy);
    cycle(1, 1, 1, a, DW'($urandom), d, rdy, 0);
  endtask

  task automatic check_reset_state();
    check("rst_wb_valid",    64'(bus.wb_valid_o),    64'(0));
    check("rst_wb_addr",     64'(bus.wb_addr_o),     64'(0));
    check("rst_wb_data",     64'(bus.wb_data_o),     64'(0));
    check("rst_issue_ready", 64'(bus.issue_ready_o), 64'(1));
  endtask

  // Asynchronous reset pulse lasting one cycle, asserted mid-cycle.
  task automatic pulse_reset();
    idle_inputs();
    resetn_i = 1'b0;
    #2;
    check_reset_state();
    exp_q.delete();
    mul_q.delete();
    @(posedge clk_i);
    #1;
    check_reset_state();
    resetn_i = 1'b1;
    cyc++;
  endtask

  initial begin
    idle_inputs();
    resetn_i = 1'b0;
    #2;
    check_reset_state();
    @(posedge clk_i);
    #1;
    resetn_i = 1'b1;
    idle(2, 1);

    // Single ALU result.
    alu_op(5'd3, 32'h0000_1234, 1);
    idle(3, 1);

    // Single MUL result.
    mul_op(5'd7, 32'hDEAD_BEEF, 1);
    idle(7, 1);

    // Collision: MUL completes in the same cycle as an ALU issue.
    mul_op(5'd1, 32'h0000_00AA, 1);
    idle(3, 1);
    alu_op(5'd2, 32'h0000_0055, 1);
    check("collision_count", 64'(exp_q.size()), 64'(2));
    check("collision_dut_count", 64'(dut.count_q), 64'(2));
    idle(4, 1);

    // Back-to-back ALU issues: push and pop at count=1.
    for (int i = 0; i < 4; i++) alu_op(AW'(10 + i), DW'($urandom), 1);
    idle(3, 1);

    // Credit / backpressure: 7 ALU + 1 MUL with the write port stalled.
    for (int i = 0; i < 7; i++) alu_op(AW'(i), DW'($urandom), 0);
    mul_op(5'd20, DW'($urandom), 0);
    for (int i = 0; i < 6; i++) alu_op(5'd30, DW'($urandom), 0);  // refused
    idle(12, 1);

    // Masked MUL: no write, no credit consumed.
    cycle(1, 1, 0, 5'd9, '0, DW'($urandom), 1, 0);
    idle(6, 1);

    // Reset mid-flight.
    alu_op(5'd4, DW'($urandom), 0);
    alu_op(5'd5, DW'($urandom), 0);
    for (int i = 0; i < 3; i++) mul_op(AW'(16 + i), DW'($urandom), 0);
    pulse_reset();
    idle(10, 1);
    alu_op(5'd6, DW'($urandom), 1);
    idle(3, 1);

    // Flush mid-flight, with an issue in the flush cycle that is dropped.
    alu_op(5'd4, DW'($urandom), 0);
    alu_op(5'd5, DW'($urandom), 0);
    for (int i = 0; i < 3; i++) mul_op(AW'(16 + i), DW'($urandom), 0);
    cycle(1, 0, 1, 5'd8, DW'($urandom), '0, 0, 1);
    idle(10, 1);
    alu_op(5'd6, DW'($urandom), 1);
    idle(3, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit v, m, en, rdy, fl;
      v   = ($urandom_range(0, 3) != 0);
      m   = ($urandom_range(0, 2) == 0);
      en  = ($urandom_range(0, 4) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 99) < 2);
      cycle(v, m, en, AW'($urandom), DW'($urandom), DW'($urandom), rdy, fl);
    end
    idle(PST + DEPTH + 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vlane_wb_align.md
# vlane_wb_align

Per-lane writeback aligner sitting directly downstream of the lane ALU. It collects single-cycle ALU results and fixed-latency multiplier results, reorders same-cycle collisions into a small result FIFO, and presents one write per cycle to the vector register file write port under a valid/ready handshake. Upstream issue is throttled with a credit scheme, so a multiplier result already in flight always has a FIFO slot.

## Interface
- DATA_WIDTH, 32, element width
- PIPE_ST, 5, multiplier stage count; multiplier result latency is PIPE_ST-1 cycles
- ADDR_W, 5, element write-address width
- FIFO_DEPTH, 8, result FIFO entries; power of 2, must be >= 2
- clk_i  in  1  clock
- resetn_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear of the FIFO and the tag pipe
- issue_valid_i  in  1  operation issued to the ALU this cycle
- issue_ready_o  out  1  aligner can accept an issue
- issue_is_mul_i  in  1  issued operation is a multiply or multiply-accumulate
- issue_mask_en_i  in  1  element active; 0 means no writeback
- issue_addr_i  in  ADDR_W  destination element address
- alu_res_i  in  DATA_WIDTH  ALU result, valid in the issue cycle
- mul_res_i  in  DATA_WIDTH  multiplier result, valid PIPE_ST-1 cycles after issue
- wb_valid_o  out  1  write request
- wb_ready_i  in  1  register file accepts the write
- wb_addr_o  out  ADDR_W  write address
- wb_data_o  out  DATA_WIDTH  write data

## Operation
- An issue is accepted when issue_valid_i && issue_ready_o. Masked-off issues (issue_mask_en_i=0) are accepted, produce no writeback, and consume no credit.
- **ALU issue (active):** {issue_addr_i, alu_res_i} is pushed into the FIFO at the accepting edge.
- **MUL issue (active):** a tag {valid, addr} enters a PIPE_ST-1 deep shift register.
  - The tag pipe advances every cycle and never stalls.
  - When a valid tag reaches the last stage, {tag.addr, mul_res_i} is pushed into the FIFO at that edge.
- **Collision:** a MUL completion and an active ALU issue in the same cycle are both pushed. The MUL entry is written first, so it is popped first.
- **Pop:** the FIFO head drives wb_*. It is popped on wb_valid_o && wb_ready_i.
- **Ordering:** FIFO order only; there is no ordering between ALU and MUL results beyond that. Write-after-write hazards to the same address are excluded upstream.
- **Credit:**
  - inflight = number of valid tags in the pipe, 0..PIPE_ST-1.
  - issue_ready_o = (count + inflight + 1 <= FIFO_DEPTH), where count is the FIFO occupancy.
  - issue_ready_o is combinational from registered state only, never from issue_valid_i.
- **Overflow:** must be impossible. A push into a full FIFO is a design error, and the bench asserts on it.
- **Flush:** flush_i clears the FIFO (count=0), all tag valids, and wb_valid_o at the next edge. Any issue presented in a flush cycle is dropped.
- **Arithmetic:** count uses $clog2(FIFO_DEPTH)+1 bits. Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:**
  - wb_valid_o=0, wb_addr_o=0, wb_data_o=0.
  - All tag valids =0, count=0.
  - issue_ready_o=1.
- **ALU latency:** issue at cycle T, wb_valid_o at T+1 at the earliest.
- **MUL latency:** issue at T, mul_res_i sampled at T+PIPE_ST-1, wb_valid_o at T+PIPE_ST at the earliest.
- **Throughput:** one pop per cycle. Up to two pushes per cycle (collision case only).
- **Stall:** while wb_valid_o=1 and wb_ready_i=0, wb_addr_o and wb_data_o hold stable.
- **Reset mid-operation:** all in-flight tags and FIFO entries are discarded with no writeback. The first issue after reset release is accepted normally.
- **Simultaneous push and pop when full:** not reachable, because the credit scheme reserves the slot.
- **Simultaneous push and pop at count=1:** legal; count stays 1.

## Configuration
- **ALU_BYPASS_EN defined:**
  - An active ALU issue bypasses the FIFO and appears on wb_* combinationally in the same cycle T.
  - Bypass applies only when all three hold: FIFO empty, no MUL completion this cycle, wb_ready_i=1.
  - A bypassed result is not pushed and consumes no entry.
  - issue_ready_o is unchanged.
- **ALU_BYPASS_EN undefined:** all results pass through the FIFO, and ALU latency is exactly 1 cycle minimum.

## Test plan
- **Single ALU result:** ALU issue at T with addr=3, alu_res_i=0x0000_1234, wb_ready_i=1 -> wb_valid_o=1 at T+1 with addr 3, data 0x1234. With ALU_BYPASS_EN the write appears at T.
- **Single MUL result:** MUL issue at T with addr=7 (PIPE_ST=5), mul_res_i=0xDEAD_BEEF at T+4 -> single write {7, 0xDEADBEEF} at T+5. No other wb_valid_o pulses occur.
- **Collision:**
  - Stimulus: MUL issue addr 1 at T; ALU issue addr 2, data 0x55 at T+4; mul_res_i=0xAA at T+4.
  - Required: writes {1,0xAA} at T+5 and {2,0x55} at T+6; count peaks at 2.
- **Credit / backpressure:**
  - Stimulus: wb_ready_i=0; issue 7 ALU ops, then 1 MUL.
  - Required: issue_ready_o=0 until a pop occurs.
  - Then raise wb_ready_i: 8 writes drain one per cycle, in order, with the MUL last.
- **Masked element:** MUL issue with issue_mask_en_i=0 and addr 9 -> no write to addr 9, inflight stays 0, issue_ready_o never drops.
- **Reset and flush mid-flight:**
  - Stimulus: 3 MUL issues plus 2 queued ALU results, then resetn_i low for 1 cycle (repeat with flush_i instead).
  - Required: wb_valid_o=0 and issue_ready_o=1 afterward. No stale writes appear in the next 10 cycles, and a new ALU issue writes back normally.
